// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the instruction-memory address and
// sequences IDLE -> RUN -> DONE with a start/done handshake for the host.
// Optional retired-instruction counter is built only when FETCH_INSTR_COUNT_EN is defined.
module fetch_unit #(
  parameter int unsigned          PC_WIDTH = 10,
  parameter int unsigned          IW       = 9,
  parameter logic [IW-1:0]        HALT_OP  = 9'b000111111
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Start,
  input  logic                Stall,
  input  logic                Branch,
  input  logic                BranchTaken,
  input  logic [PC_WIDTH-1:0] Target,
  input  logic [IW-1:0]       ImemData,
  output logic [PC_WIDTH-1:0] ImemAddr,
  output logic [IW-1:0]       Instr,
  output logic                InstrValid,
  output logic                Done,
  output logic                Fault,
  output logic [15:0]         InstrCount
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [PC_WIDTH-1:0] PcLast = {PC_WIDTH{1'b1}};

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                fault_q, fault_d;

  // State, PC and fault registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  // Next-state / next-PC selection; priority in RUN is stall, halt, branch, end-of-memory
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    unique case (state_q)
      StIdle: begin
        pc_d = '0;
        if (Start) begin
          state_d = StRun;
          fault_d = 1'b0;
        end
      end
      StRun: begin
        if (!Stall) begin
          if (ImemData == HALT_OP) begin
            state_d = StDone;
          end else if (Branch && BranchTaken) begin
            pc_d = Target;
          end else if (pc_q == PcLast) begin
            // Hold at the last address rather than wrapping to 0
            state_d = StDone;
            fault_d = 1'b1;
          end else begin
            pc_d = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
          end
        end
      end
      StDone: begin
        if (Start) begin
          state_d = StRun;
          pc_d    = '0;
          fault_d = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        pc_d    = '0;
        fault_d = 1'b0;
      end
    endcase
  end

  // Outputs decoded from registered state; instruction is forced to 0 when not fetching
  always_comb begin
    ImemAddr   = pc_q;
    InstrValid = (state_q == StRun);
    Done       = (state_q == StDone);
    Fault      = fault_q;
    Instr      = InstrValid ? ImemData : '0;
  end

`ifdef FETCH_INSTR_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Retired-instruction counter register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Clear on accepted start, saturating increment on each unstalled RUN cycle
  always_comb begin
    cnt_d = cnt_q;
    if ((state_q != StRun) && Start) begin
      cnt_d = '0;
    end else if ((state_q == StRun) && !Stall && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  assign InstrCount = cnt_q;
`else
  assign InstrCount = '0;
`endif

endmodule
